// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the single-clock FIFO RAM controller:
// pointer width, legal RAM read latencies and the full/empty pointer compare.
package fifo_ctrl_pkg;

  localparam int RD_LAT_NONPIPE = 1;
  localparam int RD_LAT_PIPE    = 2;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic bit rd_lat_legal(input int lat);
    return (lat == RD_LAT_NONPIPE) || (lat == RD_LAT_PIPE);
  endfunction

  // Pointers carry one wrap bit above the RAM address, so the masked
  // difference is the fill level and equals 2^depth_log2 exactly when full.
  function automatic ptr_flags_t ptr_flags(input logic [31:0] wptr,
                                           input logic [31:0] rptr,
                                           input int depth_log2);
    logic [31:0] mask;
    logic [31:0] diff;
    ptr_flags_t  f;
    mask    = (32'd1 << (depth_log2 + 1)) - 32'd1;
    diff    = (wptr - rptr) & mask;
    f.empty = (diff == 32'd0);
    f.full  = (diff == (32'd1 << depth_log2));
    return f;
  endfunction

endpackage

// File: rtl/fifo_ctrl_vld_pipe.sv
// Reset-cleared shift register that delays the read-accept strobe by the RAM
// read latency so that DVLD lines up with RAM read data.
module fifo_ctrl_vld_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic vld_out
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = vld_in;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld_out = sr_q[DEPTH-1];

endmodule

// File: rtl/fifo_sync_ram_ctrl.sv
// Single-clock FIFO controller driving a dual-port RAM wrapper.
// Optional sticky ECC status is enabled with macro FIFO_SYNC_RAM_CTRL_ECC_EN.
module fifo_sync_ram_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 7,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  WE,
  input  logic [WIDTH-1:0]      DATA,
  input  logic                  RE,
  output logic [WIDTH-1:0]      Q,
  output logic                  DVLD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  WACK,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [DEPTH_LOG2:0]   WRCNT,
  output logic [WIDTH-1:0]      RAM_WDATA,
  output logic [DEPTH_LOG2-1:0] RAM_WADDR,
  output logic                  RAM_WEN,
  output logic [DEPTH_LOG2-1:0] RAM_RADDR,
  output logic                  RAM_REN,
  input  logic [WIDTH-1:0]      RAM_RDATA,
  input  logic                  RAM_SB_CORRECT,
  input  logic                  RAM_DB_DETECT,
  output logic                  SB_CORRECT,
  output logic                  DB_DETECT
);

  localparam int PW = ptr_width(DEPTH_LOG2);

  generate
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("fifo_sync_ram_ctrl: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wrcnt_q, wrcnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wack_q, wack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc;
  logic          rd_acc;
  logic          dvld;
  ptr_flags_t    flags;

  // Both requests are judged on the registered flags, so a write never
  // bypasses into an empty FIFO and a read never frees space for a same-cycle write.
  always_comb begin
    wr_acc  = WE & ~full_q;
    rd_acc  = RE & ~empty_q;
    wptr_d  = wptr_q + {{(PW-1){1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{(PW-1){1'b0}}, rd_acc};
    flags   = ptr_flags(32'(wptr_d), 32'(rptr_d), DEPTH_LOG2);
    full_d  = flags.full;
    empty_d = flags.empty;
    wrcnt_d = wptr_d - rptr_d;
    wack_d  = wr_acc;
    ovf_d   = WE & full_q;
    udf_d   = RE & empty_q;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      wrcnt_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      wack_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wrcnt_q <= wrcnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      wack_q  <= wack_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ctrl_vld_pipe #(
    .DEPTH (RD_LAT)
  ) u_vld_pipe (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .vld_in  (rd_acc),
    .vld_out (dvld)
  );

  assign RAM_WEN   = wr_acc;
  assign RAM_WADDR = wptr_q[DEPTH_LOG2-1:0];
  assign RAM_WDATA = DATA;
  assign RAM_REN   = rd_acc;
  assign RAM_RADDR = rptr_q[DEPTH_LOG2-1:0];

  assign Q         = RAM_RDATA;
  assign DVLD      = dvld;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign WACK      = wack_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
  assign WRCNT     = wrcnt_q;

`ifdef FIFO_SYNC_RAM_CTRL_ECC_EN
  logic sb_q, sb_d;
  logic db_q, db_d;

  // RAM ECC flags only mean something while the read data is being presented.
  always_comb begin
    sb_d = sb_q | (RAM_SB_CORRECT & dvld);
    db_d = db_q | (RAM_DB_DETECT & dvld);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sb_q <= 1'b0;
      db_q <= 1'b0;
    end else begin
      sb_q <= sb_d;
      db_q <= db_d;
    end
  end

  assign SB_CORRECT = sb_q;
  assign DB_DETECT  = db_q;
`else
  logic unused_ecc;
  assign unused_ecc = RAM_SB_CORRECT ^ RAM_DB_DETECT;
  assign SB_CORRECT = 1'b0;
  assign DB_DETECT  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_ram_ctrl.sv
// Directed bench for fifo_sync_ram_ctrl: one instance per RAM read latency,
// each with a behavioural RAM, checked against a queue model of the FIFO.
module tb_fifo_sync_ram_ctrl;

  localparam int W     = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

`ifdef FIFO_SYNC_RAM_CTRL_ECC_EN
  localparam logic ECC_ON = 1'b1;
`else
  localparam logic ECC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         we, re, ram_sb, ram_db;
  logic [W-1:0] data;

  logic [W-1:0]  q1, q2, wdata1, wdata2, rdata1, rdata2, rd2_s1;
  logic          dvld1, dvld2, full1, full2, empty1, empty2;
  logic          wack1, wack2, ovf1, ovf2, udf1, udf2;
  logic [AW:0]   wrcnt1, wrcnt2;
  logic [AW-1:0] waddr1, waddr2, raddr1, raddr2;
  logic          wen1, wen2, ren1, ren2, sb1, sb2, db1, db2;

  fifo_sync_ram_ctrl #(.WIDTH(W), .DEPTH_LOG2(AW), .RD_LAT(1)) u_dut1 (
    .CLOCK(clk), .RESET_N(rst_n), .WE(we), .DATA(data), .RE(re),
    .Q(q1), .DVLD(dvld1), .FULL(full1), .EMPTY(empty1), .WACK(wack1),
    .OVERFLOW(ovf1), .UNDERFLOW(udf1), .WRCNT(wrcnt1),
    .RAM_WDATA(wdata1), .RAM_WADDR(waddr1), .RAM_WEN(wen1),
    .RAM_RADDR(raddr1), .RAM_REN(ren1), .RAM_RDATA(rdata1),
    .RAM_SB_CORRECT(ram_sb), .RAM_DB_DETECT(ram_db),
    .SB_CORRECT(sb1), .DB_DETECT(db1)
  );

  fifo_sync_ram_ctrl #(.WIDTH(W), .DEPTH_LOG2(AW), .RD_LAT(2)) u_dut2 (
    .CLOCK(clk), .RESET_N(rst_n), .WE(we), .DATA(data), .RE(re),
    .Q(q2), .DVLD(dvld2), .FULL(full2), .EMPTY(empty2), .WACK(wack2),
    .OVERFLOW(ovf2), .UNDERFLOW(udf2), .WRCNT(wrcnt2),
    .RAM_WDATA(wdata2), .RAM_WADDR(waddr2), .RAM_WEN(wen2),
    .RAM_RADDR(raddr2), .RAM_REN(ren2), .RAM_RDATA(rdata2),
    .RAM_SB_CORRECT(ram_sb), .RAM_DB_DETECT(ram_db),
    .SB_CORRECT(sb2), .DB_DETECT(db2)
  );

  // Non-pipelined RAM: one register on the read path.
  logic [W-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (wen1) mem1[waddr1] <= wdata1;
    if (ren1) rdata1 <= mem1[raddr1];
  end

  // Pipelined RAM: extra output register.
  logic [W-1:0] mem2 [DEPTH];
  always @(posedge clk) begin
    if (wen2) mem2[waddr2] <= wdata2;
    if (ren2) rd2_s1 <= mem2[raddr2];
    rdata2 <= rd2_s1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  int           cnt_m, wptr_m, rptr_m;
  logic [W-1:0] fifo_m[$];
  logic [W-1:0] exp1[$];
  logic [W-1:0] exp2[$];
  logic [1:0]   hist;

  // One clock of stimulus; starts just after an edge, ends 1 time unit after the next.
  task automatic step(input logic we_i, input logic re_i, input logic [W-1:0] d_i, input logic sb_i);
    logic wa, ra;
    logic [W-1:0] v;
    we = we_i; re = re_i; data = d_i; ram_sb = sb_i;
    wa = we_i && (cnt_m < DEPTH);
    ra = re_i && (cnt_m > 0);
    #1;
    check("ram_wen", 32'(wen1), 32'(wa));
    check("ram_ren", 32'(ren2), 32'(ra));
    if (wa) check("ram_waddr", 32'(waddr1), 32'(wptr_m % DEPTH));
    if (ra) check("ram_raddr", 32'(raddr2), 32'(rptr_m % DEPTH));
    if (ra) begin
      v = fifo_m.pop_front();
      exp1.push_back(v);
      exp2.push_back(v);
      rptr_m++;
      cnt_m--;
    end
    if (wa) begin
      fifo_m.push_back(d_i);
      wptr_m++;
      cnt_m++;
    end
    hist = {hist[0], ra};
    @(posedge clk);
    #1;
    $display("[%0t] we=%0b re=%0b wa=%0b ra=%0b wrcnt=%0d dvld1=%0b dvld2=%0b",
             $time, we_i, re_i, wa, ra, wrcnt1, dvld1, dvld2);
    check("wrcnt1", 32'(wrcnt1), 32'(cnt_m));
    check("wrcnt2", 32'(wrcnt2), 32'(cnt_m));
    check("full", 32'(full1), 32'(cnt_m == DEPTH));
    check("empty", 32'(empty2), 32'(cnt_m == 0));
    check("wack", 32'(wack1), 32'(wa));
    check("overflow", 32'(ovf2), 32'(we_i && !wa));
    check("underflow", 32'(udf1), 32'(re_i && !ra));
    check("dvld1", 32'(dvld1), 32'(hist[0]));
    check("dvld2", 32'(dvld2), 32'(hist[1]));
    if (hist[0] && exp1.size() > 0) check("q1", q1, exp1.pop_front());
    if (hist[1] && exp2.size() > 0) check("q2", q2, exp2.pop_front());
  endtask

  // Asserts reset asynchronously mid-cycle and checks outputs before any edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; ram_sb = 1'b0; ram_db = 1'b0;
    #1;
    check("rst_dvld1", 32'(dvld1), 32'd0);
    check("rst_dvld2", 32'(dvld2), 32'd0);
    check("rst_empty", 32'(empty1), 32'd1);
    check("rst_full", 32'(full2), 32'd0);
    check("rst_wrcnt", 32'(wrcnt1), 32'd0);
    check("rst_flags", 32'({wack1, ovf1, udf2}), 32'd0);
    check("rst_ecc", 32'({sb1, db1, sb2, db2}), 32'd0);
    cnt_m = 0; wptr_m = 0; rptr_m = 0; hist = 2'b00;
    fifo_m.delete(); exp1.delete(); exp2.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int written;
    logic we_r, re_r;
    rst_n = 1'b1; we = 1'b0; re = 1'b0; data = '0; ram_sb = 1'b0; ram_db = 1'b0;
    #3;
    apply_reset();

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(i), 1'b0);
    check("full_after_128", 32'(full1), 32'd1);
    step(1'b1, 1'b0, 32'hDEAD, 1'b0);
    check("ovf_wrcnt_128", 32'(wrcnt2), 32'd128);

    // Full with simultaneous WE/RE: read wins, write rejected.
    step(1'b1, 1'b1, 32'hBEEF, 1'b0);
    check("full_both_wrcnt", 32'(wrcnt1), 32'd127);
    check("full_both_ovf", 32'(ovf1), 32'd1);
    step(1'b1, 1'b0, 32'd128, 1'b0);

    // Drain completely, then one rejected read.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
    check("empty_after_drain", 32'(empty1), 32'd1);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Empty with simultaneous WE/RE: write wins, read rejected, no DVLD.
    step(1'b1, 1'b1, 32'h777, 1'b0);
    check("empty_both_wrcnt", 32'(wrcnt1), 32'd1);
    check("empty_both_udf", 32'(udf2), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("empty_both_nodvld", 32'({dvld1, dvld2}), 32'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Random stream of 300 words across pointer wrap, then drain.
    written = 0;
    for (int k = 0; k < 4000 && !(written >= 300 && cnt_m == 0); k++) begin
      we_r = (written < 300) && ($urandom_range(0, 3) != 0);
      re_r = ($urandom_range(0, 2) != 0);
      if (we_r && cnt_m < DEPTH) written++;
      step(we_r, re_r, 32'(1000 + written), 1'b0);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("stream_wrcnt0", 32'(wrcnt2), 32'd0);
    check("stream_empty", 32'(empty1), 32'd1);

    // ECC flag during DVLD of the latency-1 instance only.
    step(1'b1, 1'b0, 32'hA1, 1'b0);
    step(1'b1, 1'b0, 32'hA2, 1'b0);
    step(1'b1, 1'b0, 32'hA3, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("sb1_set", 32'(sb1), 32'(ECC_ON));
    check("sb2_clear", 32'(sb2), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("sb1_sticky", 32'(sb1), 32'(ECC_ON));
    check("db1_clear", 32'(db1), 32'd0);

    // Reset while a read is in flight in both pipes.
    step(1'b0, 1'b1, '0, 1'b0);
    apply_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    check("post_rst_dvld2", 32'(dvld2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
